// File: rtl/deser_pkg.sv
// deser_pkg: state encoding and default parameters for serial_deser
package deser_pkg;
  typedef enum logic [1:0] {HUNT, LOAD, PARITY} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_SYNC_LEN = 8;
  localparam logic [7:0] DEF_SYNC = 8'hA5;
endpackage

// File: rtl/serial_deser_sync_detect.sv
// sync_detect: sliding sync window over qualified bits with a match output for the incoming bit
module sync_detect
  import deser_pkg::*;
#(
  parameter int SYNC_LEN = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC = DEF_SYNC
) (
  input  logic Clk,
  input  logic clr,
  input  logic shift,
  input  logic D,
  output logic hit
);
  localparam int WL = SYNC_LEN - 1;
  logic [WL-1:0] win_q, win_d;
  // keep only the previous SYNC_LEN-1 bits; the incoming bit completes the window
  always_comb win_d = clr ? '0 : shift ? WL'({win_q, D}) : win_q;
  // window register, cleared synchronously by clr
  always_ff @(posedge Clk) win_q <= win_d;
  assign hit = shift && ({win_q, D} == SYNC);
endmodule

// File: rtl/serial_deser.sv
// serial_deser: sync-hunting serial-to-parallel deserializer; optional even parity check via PARITY_CHECK_EN
module serial_deser
  import deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SYNC_LEN = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC = DEF_SYNC
) (
  input  logic             Clk,
  input  logic             nRst,
  input  logic             D,
  input  logic             En,
  input  logic             Resync,
  output logic [WIDTH-1:0] Q,
  output logic             Valid,
  output logic             Locked,
  output logic             ParErr
);
  localparam int CW = $clog2(WIDTH);
`ifdef PARITY_CHECK_EN
  localparam int WW = WIDTH;
`else
  localparam int WW = WIDTH - 1;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] word_q, word_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic valid_q, valid_d, perr_q, perr_d, hit, last;
  assign last = cnt_q == CW'(WIDTH - 1);
  sync_detect #(.SYNC_LEN(SYNC_LEN), .SYNC(SYNC)) u_sync (
    .Clk  (Clk),
    .clr  (Resync | ~nRst),
    .shift(En && state_q == HUNT),
    .D    (D),
    .hit  (hit)
  );
  // next state: Resync wins over data, En=0 holds everything
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    word_d = word_q;
    q_d = q_q;
    valid_d = 1'b0;
    perr_d = 1'b0;
    if (Resync) begin
      state_d = HUNT;
      cnt_d = '0;
    end else if (En) begin
      case (state_q)
        HUNT: begin
          state_d = hit ? LOAD : HUNT;
          cnt_d = '0;
        end
        LOAD: begin
          word_d = WW'({word_q, D});
          cnt_d = last ? '0 : cnt_q + 1'b1;
`ifdef PARITY_CHECK_EN
          state_d = last ? PARITY : LOAD;
`else
          q_d = last ? {word_q, D} : q_q;
          valid_d = last;
`endif
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          q_d = word_q;
          valid_d = 1'b1;
          perr_d = (^word_q) != D;
          state_d = perr_d ? HUNT : LOAD;
        end
`endif
        default: state_d = HUNT;
      endcase
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!nRst) begin
      state_q <= HUNT;
      cnt_q <= '0;
      word_q <= '0;
      q_q <= '0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      q_q <= q_d;
      valid_q <= valid_d;
      perr_q <= perr_d;
    end
  end
  assign Q = q_q;
  assign Valid = valid_q;
  assign Locked = state_q != HUNT;
  assign ParErr = perr_q;
endmodule
